// File: rtl/intersection_phase_scheduler.sv
// Tick-driven green/yellow/all-red/walk sequencer for a main/side/pedestrian intersection.
// Optional PED_FLASH_EN: pedestrian light flashes during clearance instead of holding red.
module intersection_phase_scheduler #(
    parameter int unsigned MIN_GREEN = 5,
    parameter int unsigned MAX_GREEN = 9,
    parameter int unsigned YELLOW    = 3,
    parameter int unsigned ALL_RED   = 1,
    parameter int unsigned WALK      = 7,
    parameter int unsigned PED_CLR   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [1:0] ped_light,
    output logic [3:0] countdown,
    output logic [2:0] phase,
    output logic       side_wait,
    output logic       ped_wait
);

    typedef enum logic [2:0] {
        S_MAIN_G   = 3'd0,
        S_MAIN_Y   = 3'd1,
        S_ALLRED_A = 3'd2,
        S_SIDE_G   = 3'd3,
        S_SIDE_Y   = 3'd4,
        S_PED_WALK = 3'd5,
        S_PED_CLR  = 3'd6,
        S_ALLRED_B = 3'd7
    } phase_t;

    phase_t     r_phase, w_nphase;
    logic [3:0] r_cnt, w_ncnt;
    logic [3:0] r_ext, w_next_ext;
    logic       r_side_wait, r_ped_wait, r_last_ped;
    logic [2:0] r_main, r_side, w_main, w_side;
    logic [1:0] r_ped, w_ped_base;
    logic       w_entry_side, w_entry_walk;

    always_comb begin
        w_nphase   = r_phase;
        w_ncnt     = r_cnt;
        w_next_ext = r_ext;
        if (tick) begin
            if (r_phase == S_MAIN_G) begin
                // Green rest: countdown parks at 0 until something is waiting
                if (r_cnt <= 4'd1) begin
                    if (r_side_wait || r_ped_wait) begin
                        w_nphase = S_MAIN_Y;
                        w_ncnt   = 4'(YELLOW);
                    end else begin
                        w_ncnt = '0;
                    end
                end else begin
                    w_ncnt = r_cnt - 4'd1;
                end
            end else if (r_cnt > 4'd1) begin
                w_ncnt = r_cnt - 4'd1;
            end else begin
                case (r_phase)
                    S_MAIN_Y: begin
                        w_nphase = S_ALLRED_A;
                        w_ncnt   = 4'(ALL_RED);
                    end
                    S_ALLRED_A: begin
                        if (r_ped_wait && (!r_side_wait || !r_last_ped)) begin
                            w_nphase = S_PED_WALK;
                            w_ncnt   = 4'(WALK);
                        end else if (r_side_wait) begin
                            w_nphase   = S_SIDE_G;
                            w_ncnt     = 4'(MIN_GREEN);
                            w_next_ext = 4'(MAX_GREEN - MIN_GREEN);
                        end else begin
                            w_nphase = S_MAIN_G;
                            w_ncnt   = 4'(MIN_GREEN);
                        end
                    end
                    S_SIDE_G: begin
                        // Extension keeps countdown at 1 while the sensor stays occupied
                        if (side_req && (r_ext != 4'd0)) begin
                            w_next_ext = r_ext - 4'd1;
                        end else begin
                            w_nphase = S_SIDE_Y;
                            w_ncnt   = 4'(YELLOW);
                        end
                    end
                    S_SIDE_Y, S_PED_CLR: begin
                        w_nphase = S_ALLRED_B;
                        w_ncnt   = 4'(ALL_RED);
                    end
                    S_PED_WALK: begin
                        w_nphase = S_PED_CLR;
                        w_ncnt   = 4'(PED_CLR);
                    end
                    default: begin
                        w_nphase = S_MAIN_G;
                        w_ncnt   = 4'(MIN_GREEN);
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_entry_side = (w_nphase == S_SIDE_G) && (r_phase != S_SIDE_G);
        w_entry_walk = (w_nphase == S_PED_WALK) && (r_phase != S_PED_WALK);
        w_main       = 3'b100;
        w_side       = 3'b100;
        w_ped_base   = 2'b10;
        case (w_nphase)
            S_MAIN_G:   w_main     = 3'b001;
            S_MAIN_Y:   w_main     = 3'b010;
            S_SIDE_G:   w_side     = 3'b001;
            S_SIDE_Y:   w_side     = 3'b010;
            S_PED_WALK: w_ped_base = 2'b01;
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase     <= S_MAIN_G;
            r_cnt       <= 4'(MIN_GREEN);
            r_ext       <= '0;
            r_side_wait <= 1'b0;
            r_ped_wait  <= 1'b0;
            r_last_ped  <= 1'b0;
            r_main      <= 3'b001;
            r_side      <= 3'b100;
            r_ped       <= 2'b10;
        end else begin
            r_phase <= w_nphase;
            r_cnt   <= w_ncnt;
            r_ext   <= w_next_ext;
            if (w_entry_side)
                r_side_wait <= 1'b0;
            else if (side_req && (r_phase != S_SIDE_G))
                r_side_wait <= 1'b1;
            if (w_entry_walk)
                r_ped_wait <= 1'b0;
            else if (ped_req && (r_phase != S_PED_WALK) && (r_phase != S_PED_CLR))
                r_ped_wait <= 1'b1;
            if (w_entry_walk)
                r_last_ped <= 1'b1;
            else if (w_entry_side)
                r_last_ped <= 1'b0;
            r_main <= w_main;
            r_side <= w_side;
`ifdef PED_FLASH_EN
            if (tick && (r_phase == S_PED_CLR) && (w_nphase == S_PED_CLR))
                r_ped <= r_ped ^ 2'b10;
            else
                r_ped <= w_ped_base;
`else
            r_ped <= w_ped_base;
`endif
        end
    end

    assign main_light = r_main;
    assign side_light = r_side;
    assign ped_light  = r_ped;
    assign countdown  = r_cnt;
    assign phase      = r_phase;
    assign side_wait  = r_side_wait;
    assign ped_wait   = r_ped_wait;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench: elapsed-time reference model queues expected outputs, monitor compares.
module tb_intersection_phase_scheduler;

    localparam int MIN_G = 5, MAX_G = 9, YEL = 3, ALLR = 1, WLK = 7, PCLR = 3;

    logic       clk = 1'b0;
    logic       rst, tick, side_req, ped_req;
    logic [2:0] main_light, side_light, phase;
    logic [1:0] ped_light;
    logic [3:0] countdown;
    logic       side_wait, ped_wait;

    intersection_phase_scheduler #(
        .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW(YEL),
        .ALL_RED(ALLR), .WALK(WLK), .PED_CLR(PCLR)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .side_req(side_req), .ped_req(ped_req),
        .main_light(main_light), .side_light(side_light), .ped_light(ped_light),
        .countdown(countdown), .phase(phase), .side_wait(side_wait), .ped_wait(ped_wait)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] pc;   // {phase, countdown}
        logic [9:0] lw;   // {main, side, ped, side_wait, ped_wait}
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference model: phase number plus ticks elapsed in it
    int m_ph = 0, m_el = 0;
    bit m_sw = 0, m_pw = 0, m_lp = 0;

    function automatic int dur(input int ph);
        case (ph)
            1, 4:    return YEL;
            2, 7:    return ALLR;
            5:       return WLK;
            6:       return PCLR;
            default: return MIN_G;
        endcase
    endfunction

    function automatic int succ(input int ph);
        case (ph)
            1:       return 2;
            4, 6:    return 7;
            5:       return 6;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit t, input bit s, input bit p);
        int np;
        int cd;
        logic [2:0] ml, sl;
        logic [1:0] pl;
        if (r) begin
            m_ph = 0; m_el = 0; m_sw = 0; m_pw = 0; m_lp = 0;
        end else begin
            np = m_ph;
            if (t) begin
                m_el++;
                case (m_ph)
                    0: if (m_el >= MIN_G) begin
                           if (m_sw || m_pw) np = 1;
                           else m_el = MIN_G;
                       end
                    2: if (m_el >= ALLR)
                           np = (m_pw && (!m_sw || !m_lp)) ? 5 : (m_sw ? 3 : 0);
                    3: if (m_el >= MIN_G && !(s && m_el < MAX_G)) np = 4;
                    default: if (m_el >= dur(m_ph)) np = succ(m_ph);
                endcase
            end
            if (np == 3 && m_ph != 3) m_sw = 0;
            else if (s && m_ph != 3) m_sw = 1;
            if (np == 5 && m_ph != 5) m_pw = 0;
            else if (p && m_ph != 5 && m_ph != 6) m_pw = 1;
            if (np != m_ph) begin
                m_el = 0;
                if (np == 5) m_lp = 1;
                if (np == 3) m_lp = 0;
            end
            m_ph = np;
        end
        if (m_ph == 3) cd = (m_el < MIN_G) ? MIN_G - m_el : 1;
        else           cd = dur(m_ph) - m_el;
        ml = (m_ph == 0) ? 3'b001 : (m_ph == 1) ? 3'b010 : 3'b100;
        sl = (m_ph == 3) ? 3'b001 : (m_ph == 4) ? 3'b010 : 3'b100;
        pl = (m_ph == 5) ? 2'b01 : 2'b10;
`ifdef PED_FLASH_EN
        if (m_ph == 6 && (m_el % 2) == 1) pl = 2'b00;
`endif
        exp_q.push_back('{pc: {3'(m_ph), 4'(cd)}, lw: {ml, sl, pl, m_sw, m_pw}});
    endtask

    task automatic drive(input bit r, input bit t, input bit s, input bit p);
        @(negedge clk);
        rst = r; tick = t; side_req = s; ped_req = p;
        model_step(r, t, s, p);
    endtask

    // Monitor: outputs are valid every cycle once an expectation exists
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({phase, countdown} !== e.pc) begin
                    errors++;
                    $display("FAIL phase/countdown cyc=%0d got=%0d/%0d want=%0d/%0d",
                             cyc, phase, countdown, e.pc[6:4], e.pc[3:0]);
                end
                checks++;
                if ({main_light, side_light, ped_light, side_wait, ped_wait} !== e.lw) begin
                    errors++;
                    $display("FAIL lights/waits cyc=%0d got=%b want=%b", cyc,
                             {main_light, side_light, ped_light, side_wait, ped_wait}, e.lw);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; tick = 1'b0; side_req = 1'b0; ped_req = 1'b0;
        model_step(1, 0, 0, 0);
        drive(1, 1, 0, 0);
        // Idle rest: countdown runs down to 0 and holds
        repeat (20) drive(0, 1, 0, 0);
        // Single-cycle side request, full side cycle without extension
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 1, 0);
        repeat (30) drive(0, 1, 0, 0);
        // Side sensor held: maximum extension
        drive(1, 0, 1, 0);
        repeat (30) drive(0, 1, 1, 0);
        // Coincident requests: pedestrian served first
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 1);
        repeat (45) drive(0, 1, 0, 0);
        // Pedestrian button during walk must not relatch
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 1);
        for (int i = 0; i < 40 && m_ph != 5; i++) drive(0, 1, 0, 0);
        drive(0, 1, 0, 1);
        drive(0, 0, 0, 1);
        repeat (25) drive(0, 1, 0, 0);
        // Reset coincident with tick during side yellow
        drive(1, 0, 0, 0);
        for (int i = 0; i < 60 && m_ph != 4; i++) drive(0, 1, 1, 0);
        drive(1, 1, 1, 1);
        repeat (3) drive(0, 1, 0, 0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0));
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
